// File: rtl/pa_cpu.sv
// Shared CPU-wide definitions for the SOL-1 sequencer blocks.
// Holds interrupt-controller sizing and the interrupt vector encoding.
//   NUM_IRQ         : interrupt lines. Fixed at 8 because masks load from z_bus.
//   IRQ_SYNC_STAGES : synchroniser depth per line. Must be at least 2.
//   vec_of(idx)     : vector handed to the trap microcode (idx * 2).
package pa_cpu;

  localparam int NUM_IRQ         = 8;
  localparam int IRQ_SYNC_STAGES = 2;

  // Vectors are spaced two apart so each entry is a word-aligned slot in the
  // trap table.
  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return {4'b0000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/sol1_irq_sync_edge.sv
// Synchroniser and rising-edge detector for one external interrupt line.
// Ports:
//   clk  : system clock
//   arst : asynchronous active-high reset; clears the chain and the edge flop
//   irq  : asynchronous interrupt input
//   rise : one-cycle pulse when the synchronised level goes from 0 to 1
module sol1_irq_sync_edge
  import pa_cpu::*;
#(
  parameter int SYNC_STAGES = IRQ_SYNC_STAGES
) (
  input  logic clk,
  input  logic arst,
  input  logic irq,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      // Synchroniser chain: bit 0 is the metastability-exposed flop.
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], irq};
      // Edge stage: previous value of the synchronised level.
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // A level held high gives exactly one pulse.
  assign rise = sync_p0[SYNC_STAGES-1] & ~prev_p1;

endmodule

// File: rtl/sol1_interrupt_controller.sv
// SOL-1 interrupt controller.
// Latches rising edges of the board IRQ lines as pending requests. It then
// applies the software mask and priority nesting, and raises int_pending to
// the microcode sequencer. On ctrl_int_ack it grants the highest-priority
// eligible line and publishes its vector. Bit 0 has the highest priority.
// Ports:
//   clk, arst           : clock and asynchronous active-high reset
//   irq_in              : asynchronous rising-edge interrupt lines
//   z_bus               : mask write data
//   status_irq_en       : CPU status irq enable; gates int_pending only
//   ctrl_irq_masks_wrt  : load irq_masks from z_bus
//   ctrl_int_ack        : grant the highest eligible request
//   ctrl_int_eoi        : retire the highest-priority in-service line
//   ctrl_clear_all_ints : flush pending and in-service state
//   int_pending         : an eligible request exists (and irq enabled)
//   int_vector          : vector of the last granted line
//   irq_masks           : mask register (1 = enabled)
//   irq_pending         : pending latch
//   irq_in_service      : in-service register
module sol1_interrupt_controller
  import pa_cpu::*;
#(
  parameter int NUM_IRQ     = pa_cpu::NUM_IRQ,
  parameter int SYNC_STAGES = IRQ_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] z_bus,
  input  logic               status_irq_en,
  input  logic               ctrl_irq_masks_wrt,
  input  logic               ctrl_int_ack,
  input  logic               ctrl_int_eoi,
  input  logic               ctrl_clear_all_ints,
  output logic               int_pending,
  output logic [7:0]         int_vector,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_in_service
);

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] above;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] grant_oh;
  logic [NUM_IRQ-1:0] eoi_oh;
  logic [2:0]         grant_idx;
  logic               grant_hit;
  logic               eoi_hit;
  logic               ack_take;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] in_service_nxt;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    sol1_irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk  (clk),
      .arst (arst),
      .irq  (irq_in[i]),
      .rise (irq_rise[i])
    );
  end

  // above[i] is set when line i or any higher-priority line is in service.
  // Only strictly higher-priority requests can nest.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    above = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      acc      = acc | irq_in_service[i];
      above[i] = acc;
    end
  end

  assign elig        = irq_pending & irq_masks & ~above;
  assign int_pending = status_irq_en & (|elig);

  // Lowest set index wins, both for the grant and for EOI retirement.
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    grant_oh  = '0;
    eoi_hit   = 1'b0;
    eoi_oh    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant_idx = 3'(i);
        grant_hit = 1'b1;
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && (grant_oh == '0)) begin
        grant_oh[i] = 1'b1;
      end
      if (irq_in_service[i] && !eoi_hit) begin
        eoi_oh[i] = 1'b1;
        eoi_hit   = 1'b1;
      end
    end
  end

  // Ack does not look at status_irq_en; the microcode gates it.
  assign ack_take = ctrl_int_ack & grant_hit;

  // A fresh edge on the granted line re-queues it. EOI works on the old
  // in-service set before the new grant is added.
  always_comb begin
    pending_nxt    = irq_pending;
    in_service_nxt = irq_in_service;
    if (ctrl_int_eoi) begin
      in_service_nxt = in_service_nxt & ~eoi_oh;
    end
    if (ack_take) begin
      pending_nxt    = pending_nxt & ~grant_oh;
      in_service_nxt = in_service_nxt | grant_oh;
    end
    pending_nxt = pending_nxt | irq_rise;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      irq_masks      <= '0;
      irq_pending    <= '0;
      irq_in_service <= '0;
      int_vector     <= '0;
    end else begin
      if (ctrl_irq_masks_wrt) begin
        irq_masks <= z_bus;
      end
      // A flush overrides edges and acks arriving in the same cycle.
      if (ctrl_clear_all_ints) begin
        irq_pending    <= '0;
        irq_in_service <= '0;
      end else begin
        irq_pending    <= pending_nxt;
        irq_in_service <= in_service_nxt;
        if (ack_take) begin
          int_vector <= vec_of(grant_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_sol1_interrupt_controller.sv
module tb_sol1_interrupt_controller;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] irq_in = '0;
  logic [7:0] z_bus = '0;
  logic       status_irq_en = 1'b0;
  logic       ctrl_irq_masks_wrt = 1'b0;
  logic       ctrl_int_ack = 1'b0;
  logic       ctrl_int_eoi = 1'b0;
  logic       ctrl_clear_all_ints = 1'b0;
  logic       int_pending;
  logic [7:0] int_vector;
  logic [7:0] irq_masks;
  logic [7:0] irq_pending;
  logic [7:0] irq_in_service;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sol1_interrupt_controller dut (
    .clk                 (clk),
    .arst                (arst),
    .irq_in              (irq_in),
    .z_bus               (z_bus),
    .status_irq_en       (status_irq_en),
    .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
    .ctrl_int_ack        (ctrl_int_ack),
    .ctrl_int_eoi        (ctrl_int_eoi),
    .ctrl_clear_all_ints (ctrl_clear_all_ints),
    .int_pending         (int_pending),
    .int_vector          (int_vector),
    .irq_masks           (irq_masks),
    .irq_pending         (irq_pending),
    .irq_in_service      (irq_in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. An input first seen high at a posedge turns into a
  // pending request two posedges later, so the model keeps the last three
  // sampled values of irq_in.
  bit [7:0] m_pend, m_isv, m_mask, m_vec;
  bit [7:0] h1, h2, h3;
  bit [7:0] t_pend, t_isv, t_edges, t_el;
  int       t_g, t_e;

  function automatic bit [7:0] model_elig();
    bit [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      bit blocked;
      blocked = 1'b0;
      for (int j = 0; j <= i; j++) if (m_isv[j]) blocked = 1'b1;
      r[i] = m_pend[i] & m_mask[i] & !blocked;
    end
    return r;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_pend <= '0; m_isv <= '0; m_mask <= '0; m_vec <= '0;
      h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      t_edges = h2 & ~h3;
      t_el    = model_elig();
      t_g = -1;
      for (int i = 7; i >= 0; i--) if (t_el[i]) t_g = i;
      t_e = -1;
      for (int i = 7; i >= 0; i--) if (m_isv[i]) t_e = i;
      t_pend = m_pend;
      t_isv  = m_isv;
      if (ctrl_clear_all_ints) begin
        t_pend = '0;
        t_isv  = '0;
      end else begin
        if (ctrl_int_eoi && t_e >= 0) t_isv[t_e] = 1'b0;
        if (ctrl_int_ack && t_g >= 0) begin
          t_pend[t_g] = 1'b0;
          t_isv[t_g]  = 1'b1;
          m_vec <= 8'(t_g * 2);
        end
        t_pend = t_pend | t_edges;
      end
      m_pend <= t_pend;
      m_isv  <= t_isv;
      if (ctrl_irq_masks_wrt) m_mask <= z_bus;
      h3 <= h2; h2 <= h1; h1 <= irq_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_int_pending", {7'b0, int_pending}, {7'b0, status_irq_en && (model_elig() != 0)});
      check("cyc_int_vector", int_vector, m_vec);
      check("cyc_irq_masks", irq_masks, m_mask);
      check("cyc_irq_pending", irq_pending, m_pend);
      check("cyc_irq_in_service", irq_in_service, m_isv);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mask_write(input logic [7:0] v);
    z_bus = v; ctrl_irq_masks_wrt = 1'b1; tick(1); ctrl_irq_masks_wrt = 1'b0;
  endtask
  task automatic ack();   ctrl_int_ack = 1'b1; tick(1); ctrl_int_ack = 1'b0; endtask
  task automatic eoi();   ctrl_int_eoi = 1'b1; tick(1); ctrl_int_eoi = 1'b0; endtask

  initial begin
    #1 arst = 1'b1;
    chk_en = 1'b1;
    tick(2);
    check("rst_int_pending", {7'b0, int_pending}, 8'h00);
    check("rst_vector", int_vector, 8'h00);
    check("rst_masks", irq_masks, 8'h00);
    check("rst_pending", irq_pending, 8'h00);
    check("rst_in_service", irq_in_service, 8'h00);
    arst = 1'b0;
    tick(1);

    // Single request on line 3
    status_irq_en = 1'b1;
    mask_write(8'hFF);
    check("t1_masks", irq_masks, 8'hFF);
    irq_in = 8'h08;
    tick(1);
    check("t1_k_int_pending", {7'b0, int_pending}, 8'h00);
    tick(1);
    check("t1_k1_int_pending", {7'b0, int_pending}, 8'h00);
    tick(1);
    check("t1_k2_int_pending", {7'b0, int_pending}, 8'h01);
    check("t1_k2_pending", irq_pending, 8'h08);
    ack();
    check("t1_vector", int_vector, 8'h06);
    check("t1_pending", irq_pending, 8'h00);
    check("t1_in_service", irq_in_service, 8'h08);
    check("t1_int_pending", {7'b0, int_pending}, 8'h00);
    eoi();
    check("t1_eoi", irq_in_service, 8'h00);
    irq_in = 8'h00; tick(3);

    // Priority: lines 5 and 2 together
    irq_in = 8'h24; tick(3);
    check("t2_pending", irq_pending, 8'h24);
    ack();
    check("t2_vec2", int_vector, 8'h04);
    ack();
    check("t2_blocked_vec", int_vector, 8'h04);
    check("t2_blocked_isv", irq_in_service, 8'h04);
    check("t2_blocked_int", {7'b0, int_pending}, 8'h00);
    eoi();
    check("t2_eoi_int", {7'b0, int_pending}, 8'h01);
    ack();
    check("t2_vec5", int_vector, 8'h0A);
    eoi();
    irq_in = 8'h00; tick(3);

    // Nesting: line 1 preempts in-service line 4
    irq_in = 8'h10; tick(3);
    ack();
    check("t3_isv4", irq_in_service, 8'h10);
    irq_in = 8'h12; tick(3);
    check("t3_int_pending", {7'b0, int_pending}, 8'h01);
    ack();
    check("t3_isv", irq_in_service, 8'h12);
    check("t3_vec", int_vector, 8'h02);
    eoi();
    check("t3_eoi", irq_in_service, 8'h10);
    eoi();
    irq_in = 8'h00; tick(3);

    // Masking
    mask_write(8'hF7);
    irq_in = 8'h08; tick(3);
    check("t4_pending", irq_pending, 8'h08);
    check("t4_masked_int", {7'b0, int_pending}, 8'h00);
    mask_write(8'hFF);
    check("t4_unmasked_int", {7'b0, int_pending}, 8'h01);
    status_irq_en = 1'b0;
    #1;
    check("t4_disabled_int", {7'b0, int_pending}, 8'h00);
    ack();
    check("t4_vec", int_vector, 8'h06);
    check("t4_isv", irq_in_service, 8'h08);
    eoi();
    status_irq_en = 1'b1;
    irq_in = 8'h00; tick(3);

    // Edge on line 0 in the cycle that acks line 0
    irq_in = 8'h01; tick(3);
    irq_in = 8'h00; tick(3);
    check("t5_pre_pending", irq_pending, 8'h01);
    irq_in = 8'h01; tick(2);
    ack();
    check("t5_pending", irq_pending, 8'h01);
    check("t5_isv", irq_in_service, 8'h01);
    check("t5_vec", int_vector, 8'h00);
    // clear_all colliding with an edge on line 6
    irq_in = 8'h41; tick(2);
    ctrl_clear_all_ints = 1'b1; tick(1); ctrl_clear_all_ints = 1'b0;
    check("t5_clr_pending", irq_pending, 8'h00);
    check("t5_clr_isv", irq_in_service, 8'h00);
    check("t5_clr_masks", irq_masks, 8'hFF);
    tick(3);
    check("t5_edge_lost", irq_pending, 8'h00);
    irq_in = 8'h00; tick(3);

    // Reset mid-sync of line 4, line held across release
    irq_in = 8'h10; tick(1);
    arst = 1'b1;
    #1;
    check("t6_rst_masks", irq_masks, 8'h00);
    check("t6_rst_pending", irq_pending, 8'h00);
    check("t6_rst_vec", int_vector, 8'h00);
    tick(2);
    arst = 1'b0;
    tick(1);
    check("t6_p1", irq_pending, 8'h00);
    tick(1);
    check("t6_p2", irq_pending, 8'h00);
    tick(1);
    check("t6_p3", irq_pending, 8'h10);
    check("t6_int_pending", {7'b0, int_pending}, 8'h00);
    tick(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sol1_interrupt_controller.md
Name: sol1_interrupt_controller

Overview:
- Collects external interrupt lines and synchronises them to clk; latches rising edges as pending requests.
- Applies the software mask and priority nesting, and presents a single int_pending to the microcode sequencer.
- When the trap microcode pulses ctrl_int_ack, it hands the sequencer the vector of the granted line.
- Sits between board IRQ pins and the sequencer's int_pending/ctrl_int_ack/ctrl_clear_all_ints/ctrl_irq_masks_wrt signals.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; fixed at 8 because masks are loaded from the 8-bit z_bus.
- SYNC_STAGES, 2, synchroniser flops per line; minimum 2.

Ports:
- clk  input  1  system clock
- arst  input  1  reset; asynchronous, active-high
- irq_in  input  8  asynchronous interrupt lines, rising-edge triggered; bit 0 = highest priority
- z_bus  input  8  source for mask writes
- status_irq_en  input  1  CPU status irq enable
- ctrl_irq_masks_wrt  input  1  load masks from z_bus
- ctrl_int_ack  input  1  grant the highest eligible request
- ctrl_int_eoi  input  1  end of interrupt; retire the highest-priority in-service line
- ctrl_clear_all_ints  input  1  flush pending and in-service state
- int_pending  output  1  eligible request exists
- int_vector  output  8  vector of the last granted line
- irq_masks  output  8  mask register readback; 1 = enabled
- irq_pending  output  8  pending latch readback
- irq_in_service  output  8  in-service readback

Behaviour:
- Reset (arst high, asynchronous): all outputs 0, synchroniser and edge flops 0.
- State is held in registers only; no separate FSM. Every register updates on posedge clk.
- Sync and edge detect, per line i:
  - sync chain of SYNC_STAGES flops; s = last stage; prev = s delayed one clk.
  - edge_i = s & ~prev.
  - If irq_in is first sampled high at posedge k, with SYNC_STAGES=2: pending_i sets at posedge k+2, and int_pending can be high after posedge k+2.
  - A level held high produces exactly one edge.
- Eligibility:
  - elig = pending & masks & ~above, where above_i = 1 if any in_service bit j <= i is set. Only strictly higher-priority lines can nest.
  - int_pending = status_irq_en & |elig. This is combinational from registers.
- Ack, on a posedge with ctrl_int_ack=1:
  - g = lowest index set in elig.
  - pending_g <= 0, in_service_g <= 1, int_vector <= {4'b0000, g[2:0], 1'b0}, i.e. g*2.
  - If elig = 0 (masked, disabled or nested-out): ignored, no state changes.
  - Ack ignores status_irq_en; the microcode is responsible for gating it.
- EOI: clears the lowest-index set bit of in_service. No effect if in_service = 0.
- Mask write: masks <= z_bus. A masked pending bit stays latched and becomes eligible when unmasked.
- clear_all: pending <= 0, in_service <= 0. Masks and int_vector are unchanged.
- Simultaneous events, in priority order:
  - clear_all beats an edge and an ack in the same cycle; all pending cleared, edges lost.
  - An edge on line g beats the ack clear of pending_g, so pending_g stays 1 (new event queued). in_service_g is still set.
  - Ack and EOI together: EOI is evaluated on the old in_service, then the ack bit is set.
  - Ack and mask write together: ack uses the old masks.
- Reset asserted mid-sequence drops all in-flight state. Edges synchronised before reset are lost. A line already high at reset release produces an edge after SYNC_STAGES+1 clocks.

Decomposition:
- pa_cpu gains NUM_IRQ, IRQ_SYNC_STAGES and the vector encoding function vec_of(idx) = idx<<1.
- Sub-module sol1_irq_sync_edge (synchroniser + edge detector, one per line, generate loop).
- Priority encoder and the above-mask logic stay inline in sol1_interrupt_controller.

Test Plan:
- Single request: masks=8'hFF, irq_en=1, irq_in[3] rises sampled at posedge 10 -> int_pending=1 after posedge 12. Ack at posedge 14 -> int_vector=8'h06, pending=8'h00, in_service=8'h08, int_pending=0.
- Priority: irq 5 and 2 rise together; ack -> vector 8'h04. Ack again -> nothing, since 5 is blocked by in_service 2. EOI -> int_pending=1. Ack -> vector 8'h0A.
- Nesting: in_service=8'h10. irq 1 rises -> int_pending=1, ack -> in_service=8'h12. EOI -> in_service=8'h10.
- Mask: masks=8'hF7, irq 3 rises -> pending=8'h08, int_pending=0. Write z_bus=8'hFF -> int_pending=1 next cycle. Ack with irq_en=0 still grants vector 8'h06.
- Collisions: edge on line 0 in the ack cycle granting 0 -> pending[0]=1, in_service[0]=1. clear_all with edge on line 6 -> pending=0, in_service=0, masks unchanged.
- Reset: arst pulsed mid-sync of irq 4 -> all outputs 0 immediately, no pending afterwards. Line held high across release -> pending=8'h10 at the 3rd posedge after release.
